// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in, serial-out serializer.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    localparam int unsigned PISO_WIDTH_DEF = 4;

endpackage : piso_pkg

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer: accepts a word on a valid/ready load
// handshake and emits it one bit per clock with valid and last-bit flags.
// Words stream back-to-back: the next word loads on the cycle its
// predecessor's final bit is on the line.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = PISO_WIDTH_DEF,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid_i,
    input  logic [WIDTH-1:0] load_data_i,
    output logic             load_ready_o,
    output logic             x_o,
    output logic             x_valid_o,
    output logic             last_o,
    output logic             busy_o
);

    localparam int unsigned   CW      = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
    localparam bit            SINGLE  = (WIDTH == 1);

    piso_state_t      state;
    piso_state_t      state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] sh_next;
    logic [CW-1:0]    cnt;
    logic             cnt_last;
    logic             xfer;
    logic             first_bit;
    logic             next_bit;

    // Handshake and next-state; cnt tracks the index of the bit now on x_o.
    always_comb begin
        cnt_last     = 1'b0;
        load_ready_o = 1'b0;
        xfer         = 1'b0;
        state_next   = state;

        cnt_last     = (cnt == CNT_MAX);
        load_ready_o = (state == IDLE) || ((state == SHIFT) && cnt_last);
        xfer         = load_valid_i && load_ready_o;

        case (state)
            IDLE:  if (xfer) state_next = SHIFT;
            SHIFT: if (cnt_last && !xfer) state_next = IDLE;
        endcase
    end

    // Shift path: register moves toward the send end, next bit read from there.
    always_comb begin
        sh_next   = '0;
        first_bit = 1'b0;
        next_bit  = 1'b0;

        sh_next   = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
        first_bit = MSB_FIRST ? load_data_i[WIDTH-1] : load_data_i[0];
        next_bit  = MSB_FIRST ? sh_next[WIDTH-1] : sh_next[0];
    end

    // State, shift register, bit counter and registered serial outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            x_o       <= 1'b0;
            x_valid_o <= 1'b0;
            last_o    <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            state <= state_next;
            if (xfer) begin
                shreg     <= load_data_i;
                cnt       <= '0;
                x_o       <= first_bit;
                x_valid_o <= 1'b1;
                last_o    <= SINGLE;
                busy_o    <= 1'b1;
            end else if ((state == SHIFT) && !cnt_last) begin
                shreg     <= sh_next;
                cnt       <= cnt + CW'(1);
                x_o       <= next_bit;
                x_valid_o <= 1'b1;
                last_o    <= ((cnt + CW'(1)) == CNT_MAX);
                busy_o    <= 1'b1;
            end else begin
                cnt       <= '0;
                x_o       <= 1'b0;
                x_valid_o <= 1'b0;
                last_o    <= 1'b0;
                busy_o    <= 1'b0;
            end
        end
    end

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed scenarios plus random traffic on three
// configurations, checked against a queue-of-pending-bits reference model.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset;
    int         checks = 0;
    int         failures = 0;

    // 4-bit MSB-first, 1-bit, and 5-bit LSB-first instances
    logic       lv4, rdy4, x4, xv4, last4, busy4;
    logic [3:0] ld4;
    logic       lv1, rdy1, x1, xv1, last1, busy1;
    logic [0:0] ld1;
    logic       lv5, rdy5, x5, xv5, last5, busy5;
    logic [4:0] ld5;

    bit q4[$];
    bit q1[$];
    bit q5[$];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut4 (
        .clk(clk), .reset(reset), .load_valid_i(lv4), .load_data_i(ld4),
        .load_ready_o(rdy4), .x_o(x4), .x_valid_o(xv4), .last_o(last4), .busy_o(busy4)
    );

    piso_serializer #(.WIDTH(1), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .reset(reset), .load_valid_i(lv1), .load_data_i(ld1),
        .load_ready_o(rdy1), .x_o(x1), .x_valid_o(xv1), .last_o(last1), .busy_o(busy1)
    );

    piso_serializer #(.WIDTH(5), .MSB_FIRST(1'b0)) dut5 (
        .clk(clk), .reset(reset), .load_valid_i(lv5), .load_data_i(ld5),
        .load_ready_o(rdy5), .x_o(x5), .x_valid_o(xv5), .last_o(last5), .busy_o(busy5)
    );

    // Reference model: each queue holds the bits still to appear on the line,
    // head = bit on the line now. A word is accepted when at most its
    // predecessor's final bit remains, and is queued in send order.
    always @(posedge clk) begin
        if (reset) begin
            q4.delete();
            q1.delete();
            q5.delete();
        end else begin
            if (lv4 && q4.size() <= 1) begin
                q4.delete();
                for (int i = 3; i >= 0; i--) q4.push_back(ld4[i]);
            end else if (q4.size() > 0) begin
                void'(q4.pop_front());
            end
            if (lv1 && q1.size() <= 1) begin
                q1.delete();
                q1.push_back(ld1[0]);
            end else if (q1.size() > 0) begin
                void'(q1.pop_front());
            end
            if (lv5 && q5.size() <= 1) begin
                q5.delete();
                for (int i = 0; i < 5; i++) q5.push_back(ld5[i]);
            end else if (q5.size() > 0) begin
                void'(q5.pop_front());
            end
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("m4_x",    x4,    q4.size() > 0 ? q4[0] : 1'b0);
        chk("m4_xv",   xv4,   q4.size() > 0);
        chk("m4_last", last4, q4.size() == 1);
        chk("m4_busy", busy4, q4.size() > 0);
        chk("m4_rdy",  rdy4,  q4.size() <= 1);
        chk("m1_x",    x1,    q1.size() > 0 ? q1[0] : 1'b0);
        chk("m1_xv",   xv1,   q1.size() > 0);
        chk("m1_last", last1, q1.size() == 1);
        chk("m1_busy", busy1, q1.size() > 0);
        chk("m1_rdy",  rdy1,  q1.size() <= 1);
        chk("m5_x",    x5,    q5.size() > 0 ? q5[0] : 1'b0);
        chk("m5_xv",   xv5,   q5.size() > 0);
        chk("m5_last", last5, q5.size() == 1);
        chk("m5_busy", busy5, q5.size() > 0);
        chk("m5_rdy",  rdy5,  q5.size() <= 1);
    endtask

    // Advance one clock, then compare every instance against the model.
    task automatic tick();
        @(negedge clk);
        check_model();
    endtask

    // Directed expectation on the 4-bit instance with literal values.
    task automatic exp4(input string tag, input logic ex, input logic exv,
                        input logic elast, input logic erdy);
        chk({tag, "_x"},    x4,    ex);
        chk({tag, "_xv"},   xv4,   exv);
        chk({tag, "_last"}, last4, elast);
        chk({tag, "_busy"}, busy4, exv);
        chk({tag, "_rdy"},  rdy4,  erdy);
    endtask

    task automatic exp1(input string tag, input logic ex, input logic exv,
                        input logic elast, input logic erdy);
        chk({tag, "_x"},    x1,    ex);
        chk({tag, "_xv"},   xv1,   exv);
        chk({tag, "_last"}, last1, elast);
        chk({tag, "_busy"}, busy1, exv);
        chk({tag, "_rdy"},  rdy1,  erdy);
    endtask

    initial begin
        logic [7:0] seq;
        logic [3:0] w;

        reset = 1'b1;
        lv4 = 1'b0; ld4 = '0;
        lv1 = 1'b0; ld1 = '0;
        lv5 = 1'b0; ld5 = '0;

        // Reset for two cycles, then first post-reset cycle
        tick();
        tick();
        reset = 1'b0;
        exp4("rst", 1'b0, 1'b0, 1'b0, 1'b1);
        exp1("rst1", 1'b0, 1'b0, 1'b0, 1'b1);

        // Single word 1011, MSB first
        lv4 = 1'b1; ld4 = 4'b1011;
        tick();
        lv4 = 1'b0;
        w = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            exp4($sformatf("single%0d", k), w[3-k], 1'b1, k == 3, k == 3);
            tick();
        end
        exp4("single_idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back 1011 then 0110 with load_valid_i held
        lv4 = 1'b1; ld4 = 4'b1011;
        tick();
        ld4 = 4'b0110;
        seq = 8'b1011_0110;
        for (int k = 0; k < 8; k++) begin
            exp4($sformatf("b2b%0d", k), seq[7-k], 1'b1, (k == 3) || (k == 7),
                 (k == 3) || (k == 7));
            tick();
            if (k == 3) lv4 = 1'b0;
        end
        exp4("b2b_idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // Offer ignored while shifting (cnt==1)
        lv4 = 1'b1; ld4 = 4'b1011;
        tick();
        for (int k = 0; k < 4; k++) begin
            exp4($sformatf("ign%0d", k), w[3-k], 1'b1, k == 3, k == 3);
            lv4 = (k == 1);
            ld4 = (k == 1) ? 4'b0000 : 4'b1011;
            tick();
        end
        exp4("ign_idle0", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        exp4("ign_idle1", 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-word after bit 2 of 1011
        lv4 = 1'b1; ld4 = 4'b1011;
        tick();
        lv4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp4($sformatf("mid%0d", k), w[3-k], 1'b1, 1'b0, 1'b0);
            if (k < 2) tick();
        end
        reset = 1'b1;
        tick();
        exp4("mid_rst", 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        tick();
        exp4("mid_after", 1'b0, 1'b0, 1'b0, 1'b1);

        // WIDTH=1 streaming with alternating data
        lv1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ld1 = (k == 1) ? 1'b0 : 1'b1;
            tick();
            exp1($sformatf("w1_%0d", k), (k == 1) ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b1);
        end
        lv1 = 1'b0;
        tick();
        exp1("w1_idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic on all instances with occasional reset
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            lv4 = ($urandom_range(0, 3) != 0);
            ld4 = 4'($urandom);
            lv1 = ($urandom_range(0, 3) != 0);
            ld1 = 1'($urandom);
            lv5 = ($urandom_range(0, 2) != 0);
            ld5 = 5'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_piso_serializer
